noc_ring_failover_ctrl: RTL and testbench
=========================================

NOC_RING_FAILOVER_CTRL -- requirements
Module: noc_ring_failover_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3: retries per packet before escalation (range 1..15).
REQ-002 SHALL have parameter SWAP_CYCLES, default 3: traffic-stall length of a ring swap (range 2..7).
REQ-003 SHALL have port clk_1p6ghz  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port parity_error  in  1: packet on the active ring failed parity this cycle.
REQ-006 SHALL have port pkt_ok  in  1: packet delivered clean on the active ring this cycle.
REQ-007 SHALL have port retry_ack  in  1: sender accepted the pending retry.
REQ-008 SHALL have port restore_req  in  1: request to return from Ring 1 to Ring 0.
REQ-009 SHALL have port veto_pulse  out  1: one-cycle C190 veto per sampled parity_error.
REQ-010 SHALL have port retry_request  out  1: retry pending; held until retry_ack.
REQ-011 SHALL have port ring_sel  out  1: active ring, 0 = Ring 0 primary, 1 = Ring 1 backup.
REQ-012 SHALL have port traffic_stall  out  1: NoC injection halted during a swap.
REQ-013 SHALL have port failover_event  out  1: one-cycle pulse on every ring_sel change.
REQ-014 SHALL have port fatal  out  1: sticky; retries exhausted on Ring 1.
REQ-015 SHALL have port fsm_state  out  3: current state encoding, for debug.

Function
REQ-016 SHALL register all outputs; each output responds one cycle after the sampled input or state change that causes it.
REQ-017 SHALL assert veto_pulse for one cycle after every cycle with parity_error high, in every state, including FATAL.
REQ-018 SHALL implement states IDLE, RETRY, WAIT, SWAP, FATAL.
REQ-019 In IDLE, parity_error SHALL go to RETRY with retry_cnt=1; restore_req with ring_sel=1 SHALL go to SWAP.
REQ-020 In IDLE, restore_req with ring_sel=0 SHALL be ignored.
REQ-021 In RETRY, retry_request SHALL be high; retry_ack SHALL go to WAIT; parity_error SHALL not change retry_cnt.
REQ-022 In WAIT, pkt_ok SHALL go to IDLE and clear retry_cnt.
REQ-023 In WAIT, parity_error with retry_cnt<MAX_RETRY SHALL go to RETRY and increment retry_cnt.
REQ-024 In WAIT, parity_error with retry_cnt==MAX_RETRY SHALL go to SWAP if ring_sel=0, otherwise to FATAL.
REQ-025 If parity_error and pkt_ok are both high in WAIT, parity_error SHALL win.
REQ-026 SWAP SHALL hold traffic_stall high for exactly SWAP_CYCLES cycles, counted by swap_cnt, and ignore parity_error, pkt_ok, retry_ack and restore_req except for veto.
REQ-027 On SWAP exit, SHALL toggle ring_sel, pulse failover_event, clear retry_cnt and go to IDLE.
REQ-028 FATAL SHALL be terminal until rst; fatal=1 and retry_request=0.
REQ-029 retry_cnt (4 bits) and swap_cnt (3 bits) SHALL never wrap; each saturates at its parameter bound.

Reset
REQ-030 On rst, SHALL set state IDLE, ring_sel=0 and all other outputs and counters 0; fatal is cleared only by rst.
REQ-031 rst SHALL take priority over all inputs, including mid-SWAP; a swap in progress is aborted and ring_sel returns to 0.

Configuration
REQ-032 With NOC_FAILOVER_STATS_EN defined, SHALL add outputs err_count (16 bits, counts parity_error cycles) and swap_count (8 bits, counts SWAP exits); both saturate and both reset to 0.
REQ-033 Without NOC_FAILOVER_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 A shared package noc_ctrl_pkg SHALL hold the state enum, the fsm_state encodings (IDLE=0, RETRY=1, WAIT=2, SWAP=3, FATAL=4) and the RING0/RING1 constants.
REQ-035 The swap timer SHALL be a sub-module noc_swap_timer (start in; busy and done out).

Verification (MAX_RETRY=3, SWAP_CYCLES=3)
REQ-036 Single parity_error in IDLE, retry_ack after 2 cycles, then pkt_ok -> one veto_pulse, retry_request high for 2 cycles, return to IDLE, ring_sel=0.
REQ-037 Four consecutive failures (parity_error, ack, parity_error) on Ring 0 -> 3 retries, then traffic_stall high for exactly 3 cycles, failover_event pulses once, ring_sel=1.
REQ-038 Same four-failure sequence on Ring 1 -> FATAL, fatal=1, retry_request=0, and parity_error still produces veto_pulse.
REQ-039 parity_error and pkt_ok in the same WAIT cycle -> retry_cnt increments and state goes to RETRY.
REQ-040 rst asserted on the 2nd SWAP cycle -> next cycle: IDLE, ring_sel=0, traffic_stall=0, no failover_event.
REQ-041 restore_req on Ring 1 in IDLE -> 3-cycle stall, ring_sel=0; restore_req on Ring 0 -> no effect.

Source files
------------

// File: rtl/noc_ctrl_pkg.sv
// rtl/noc_ctrl_pkg.sv - shared types and constants for the NoC ring failover controller
// Contents: state_e (fsm_state encodings IDLE=0, RETRY=1, WAIT=2, SWAP=3, FATAL=4),
//           RING0/RING1 ring_sel values, and the counter widths.
package noc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RETRY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SWAP  = 3'd3,
        ST_FATAL = 3'd4
    } state_e;

    localparam logic RING0 = 1'b0;
    localparam logic RING1 = 1'b1;

    localparam int RETRY_CNT_W = 4;
    localparam int SWAP_CNT_W  = 3;

endpackage

// File: rtl/noc_swap_timer.sv
// rtl/noc_swap_timer.sv - stall timer for a ring swap
// Ports: clk, rst (sync, active-high), start (begin a swap; only honoured while idle),
//        busy (swap in progress), done (last stall cycle of the swap).
// The counter saturates at SWAP_CYCLES and never wraps.
module noc_swap_timer
    import noc_ctrl_pkg::*;
#(
    parameter int SWAP_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam logic [SWAP_CNT_W-1:0] SWAP_LAST = SWAP_CNT_W'(SWAP_CYCLES);

    logic [SWAP_CNT_W-1:0] swap_cnt_q;
    logic [SWAP_CNT_W-1:0] swap_cnt_d;

    assign busy = (swap_cnt_q != '0);
    assign done = (swap_cnt_q == SWAP_LAST);

    // Count 1..SWAP_CYCLES; the cycle holding SWAP_CYCLES is the final stall cycle.
    always_comb begin
        swap_cnt_d = swap_cnt_q;
        if (start && !busy) begin
            swap_cnt_d = SWAP_CNT_W'(1);
        end else if (done) begin
            swap_cnt_d = '0;
        end else if (busy && (swap_cnt_q < SWAP_LAST)) begin
            swap_cnt_d = swap_cnt_q + SWAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swap_cnt_q <= '0;
        end else begin
            swap_cnt_q <= swap_cnt_d;
        end
    end

endmodule

// File: rtl/noc_ring_failover_ctrl.sv
// rtl/noc_ring_failover_ctrl.sv - parity retry / ring failover controller for a dual-ring NoC
// Ports: clk_1p6ghz, rst (sync, active-high); inputs parity_error, pkt_ok, retry_ack,
//        restore_req; registered outputs veto_pulse, retry_request, ring_sel, traffic_stall,
//        failover_event, fatal, fsm_state[2:0].
// Option NOC_FAILOVER_STATS_EN adds err_count[15:0] (parity_error cycles) and
//        swap_count[7:0] (completed swaps), both saturating.
module noc_ring_failover_ctrl
    import noc_ctrl_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int SWAP_CYCLES = 3
) (
    input  logic       clk_1p6ghz,
    input  logic       rst,
    input  logic       parity_error,
    input  logic       pkt_ok,
    input  logic       retry_ack,
    input  logic       restore_req,
    output logic       veto_pulse,
    output logic       retry_request,
    output logic       ring_sel,
    output logic       traffic_stall,
    output logic       failover_event,
    output logic       fatal,
`ifdef NOC_FAILOVER_STATS_EN
    output logic [15:0] err_count,
    output logic [7:0]  swap_count,
`endif
    output logic [2:0] fsm_state
);

    localparam logic [RETRY_CNT_W-1:0] MAX_RETRY_C = RETRY_CNT_W'(MAX_RETRY);

    state_e                 state_q, state_d;
    logic [RETRY_CNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic                   ring_sel_q, ring_sel_d;
    logic                   swap_exit;
    logic                   swap_start, swap_busy, swap_done;

    logic veto_pulse_q, veto_pulse_d;
    logic retry_request_q, retry_request_d;
    logic traffic_stall_q, traffic_stall_d;
    logic failover_event_q, failover_event_d;
    logic fatal_q, fatal_d;

    // The timer is kicked on the cycle the FSM decides to enter SWAP, so the
    // stall window lines up with the SWAP state.
    assign swap_start = (state_d == ST_SWAP) && !swap_busy;

    noc_swap_timer #(
        .SWAP_CYCLES(SWAP_CYCLES)
    ) u_swap_timer (
        .clk  (clk_1p6ghz),
        .rst  (rst),
        .start(swap_start),
        .busy (swap_busy),
        .done (swap_done)
    );

    // State register and registered outputs
    always_ff @(posedge clk_1p6ghz) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            retry_cnt_q      <= '0;
            ring_sel_q       <= RING0;
            veto_pulse_q     <= 1'b0;
            retry_request_q  <= 1'b0;
            traffic_stall_q  <= 1'b0;
            failover_event_q <= 1'b0;
            fatal_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            retry_cnt_q      <= retry_cnt_d;
            ring_sel_q       <= ring_sel_d;
            veto_pulse_q     <= veto_pulse_d;
            retry_request_q  <= retry_request_d;
            traffic_stall_q  <= traffic_stall_d;
            failover_event_q <= failover_event_d;
            fatal_q          <= fatal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        ring_sel_d  = ring_sel_q;
        swap_exit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (parity_error) begin
                    state_d     = ST_RETRY;
                    retry_cnt_d = RETRY_CNT_W'(1);
                end else if (restore_req && (ring_sel_q == RING1)) begin
                    state_d = ST_SWAP;
                end
            end
            ST_RETRY: begin
                if (retry_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // parity_error outranks pkt_ok in the same cycle
                if (parity_error) begin
                    if (retry_cnt_q < MAX_RETRY_C) begin
                        state_d     = ST_RETRY;
                        retry_cnt_d = retry_cnt_q + RETRY_CNT_W'(1);
                    end else if (ring_sel_q == RING0) begin
                        state_d = ST_SWAP;
                    end else begin
                        state_d = ST_FATAL;
                    end
                end else if (pkt_ok) begin
                    state_d     = ST_IDLE;
                    retry_cnt_d = '0;
                end
            end
            ST_SWAP: begin
                if (swap_done) begin
                    state_d     = ST_IDLE;
                    ring_sel_d  = ~ring_sel_q;
                    retry_cnt_d = '0;
                    swap_exit   = 1'b1;
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: computed from the next state so outputs track it with one register stage
    always_comb begin
        veto_pulse_d     = parity_error;
        retry_request_d  = (state_d == ST_RETRY);
        traffic_stall_d  = (state_d == ST_SWAP);
        failover_event_d = swap_exit;
        fatal_d          = (state_d == ST_FATAL);
    end

    assign veto_pulse     = veto_pulse_q;
    assign retry_request  = retry_request_q;
    assign ring_sel       = ring_sel_q;
    assign traffic_stall  = traffic_stall_q;
    assign failover_event = failover_event_q;
    assign fatal          = fatal_q;
    assign fsm_state      = state_q;

`ifdef NOC_FAILOVER_STATS_EN
    logic [15:0] err_count_q, err_count_d;
    logic [7:0]  swap_count_q, swap_count_d;

    always_comb begin
        err_count_d  = err_count_q;
        swap_count_d = swap_count_q;
        if (parity_error && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
        if (swap_exit && (swap_count_q != 8'hFF)) begin
            swap_count_d = swap_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_1p6ghz) begin
        if (rst) begin
            err_count_q  <= '0;
            swap_count_q <= '0;
        end else begin
            err_count_q  <= err_count_d;
            swap_count_q <= swap_count_d;
        end
    end

    assign err_count  = err_count_q;
    assign swap_count = swap_count_q;
`endif

endmodule

// File: tb/tb_noc_ring_failover_ctrl.sv
// tb/tb_noc_ring_failover_ctrl.sv - scoreboard bench for noc_ring_failover_ctrl
module tb_noc_ring_failover_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       parity_error = 1'b0;
    logic       pkt_ok = 1'b0;
    logic       retry_ack = 1'b0;
    logic       restore_req = 1'b0;
    logic       veto_pulse, retry_request, ring_sel, traffic_stall, failover_event, fatal;
    logic [2:0] fsm_state;
`ifdef NOC_FAILOVER_STATS_EN
    logic [15:0] err_count;
    logic [7:0]  swap_count;
`endif

    always #5 clk = ~clk;

    noc_ring_failover_ctrl #(
        .MAX_RETRY(3),
        .SWAP_CYCLES(3)
    ) dut (
        .clk_1p6ghz    (clk),
        .rst           (rst),
        .parity_error  (parity_error),
        .pkt_ok        (pkt_ok),
        .retry_ack     (retry_ack),
        .restore_req   (restore_req),
        .veto_pulse    (veto_pulse),
        .retry_request (retry_request),
        .ring_sel      (ring_sel),
        .traffic_stall (traffic_stall),
        .failover_event(failover_event),
        .fatal         (fatal),
`ifdef NOC_FAILOVER_STATS_EN
        .err_count     (err_count),
        .swap_count    (swap_count),
`endif
        .fsm_state     (fsm_state)
    );

    // Expected vector layout: {veto, retry_req, ring_sel, stall, failover_event, fatal, fsm_state[2:0]}
    logic [8:0] exp_q[$];
    string      tag_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [8:0] ex(input bit v, input bit r, input bit ring, input bit st,
                                      input bit fev, input bit fat, input logic [2:0] s);
        return {v, r, ring, st, fev, fat, s};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge
    task automatic step(input string tag, input bit r, input bit pe, input bit ok,
                        input bit ack, input bit rr, input logic [8:0] e);
        @(negedge clk);
        rst          = r;
        parity_error = pe;
        pkt_ok       = ok;
        retry_ack    = ack;
        restore_req  = rr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Three rounds of parity_error + retry_ack, leaving the FSM in WAIT with retry_cnt=3
    task automatic three_retries(input string tag, input bit ring);
        for (int i = 0; i < 3; i++) begin
            step({tag, "_pe"},  0, 1, 0, 0, 0, ex(1, 1, ring, 0, 0, 0, 3'd1));
            step({tag, "_ack"}, 0, 0, 0, 1, 0, ex(0, 0, ring, 0, 0, 0, 3'd2));
        end
    endtask

    // Ring 0 -> Ring 1 via exhausted retries
    task automatic failover_to_ring1(input string tag);
        three_retries(tag, 0);
        step({tag, "_enter_swap"}, 0, 1, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 3'd3));
        step({tag, "_swap2"},      0, 0, 1, 1, 1, ex(0, 0, 0, 1, 0, 0, 3'd3));
        step({tag, "_swap3_veto"}, 0, 1, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 3'd3));
        step({tag, "_exit"},       0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1, 0, 3'd0));
        step({tag, "_idle_r1"},    0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0, 3'd0));
    endtask

    // Monitor: one registered output snapshot per cycle, sampled after the rising edge
    initial begin
        logic [8:0] e;
        logic [8:0] act;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = {veto_pulse, retry_request, ring_sel, traffic_stall,
                       failover_event, fatal, fsm_state};
                n_cmp++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL %s: veto/rreq/ring/stall/fev/fatal/state got %b expected %b", t, act, e);
                end
            end
        end
    end

    initial begin
        // Reset, including reset winning over every active input
        step("rst0",    1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("rst_pri", 1, 1, 1, 1, 1, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("idle0",   0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));

        // Single error, ack two cycles later, then clean delivery
        step("a_pe",    0, 1, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 3'd1));
        step("a_hold",  0, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 3'd1));
        step("a_ack",   0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 3'd2));
        step("a_ok",    0, 0, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("a_idle",  0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));

        // Four failures on Ring 0 -> 3-cycle swap to Ring 1
        failover_to_ring1("b");

        // Restore from Ring 1, then restore on Ring 0 is ignored
        step("r_req",    0, 0, 0, 0, 1, ex(0, 0, 1, 1, 0, 0, 3'd3));
        step("r_swap2",  0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0, 3'd3));
        step("r_swap3",  0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0, 3'd3));
        step("r_exit",   0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 3'd0));
        step("r_ring0",  0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("r_idle",   0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));

        // parity_error beats pkt_ok in WAIT
        step("d_pe",     0, 1, 0, 0, 0, ex(1, 1, 0, 0, 0, 0, 3'd1));
        step("d_ack",    0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 3'd2));
        step("d_pe_ok",  0, 1, 1, 0, 0, ex(1, 1, 0, 0, 0, 0, 3'd1));
        step("d_ack2",   0, 0, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 3'd2));
        step("d_ok",     0, 0, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("d_noise",  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));

        // Four failures on Ring 1 -> FATAL, veto still works, terminal until reset
        failover_to_ring1("c_pre");
        three_retries("c", 1);
        step("c_fatal",  0, 1, 0, 0, 0, ex(1, 0, 1, 0, 0, 1, 3'd4));
        step("c_hold",   0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 1, 3'd4));
        step("c_veto",   0, 1, 0, 0, 0, ex(1, 0, 1, 0, 0, 1, 3'd4));
        step("c_rr",     0, 0, 0, 0, 1, ex(0, 0, 1, 0, 0, 1, 3'd4));
        step("c_ackok",  0, 0, 1, 1, 0, ex(0, 0, 1, 0, 0, 1, 3'd4));
        step("c_rst",    1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));

        // Reset on the 2nd cycle of a Ring 0 swap
        three_retries("e", 0);
        step("e_swap1",  0, 1, 0, 0, 0, ex(1, 0, 0, 1, 0, 0, 3'd3));
        step("e_swap2",  0, 0, 0, 0, 0, ex(0, 0, 0, 1, 0, 0, 3'd3));
        step("e_rst",    1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("e_after1", 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("e_after2", 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));

        // Reset on the 2nd cycle of a restore swap: ring_sel drops back to 0
        failover_to_ring1("f_pre");
        step("f_req",    0, 0, 0, 0, 1, ex(0, 0, 1, 1, 0, 0, 3'd3));
        step("f_swap2",  0, 0, 0, 0, 0, ex(0, 0, 1, 1, 0, 0, 3'd3));
        step("f_rst",    1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("f_after",  0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));
        step("f_after2", 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 3'd0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
